// File: rtl/echo_ctrl.sv
// echo_ctrl: echo delay-line controller that mixes in the sample from DELAY samples ago with feedback gain
// and writes the saturated mix back into the circular sample buffer
module echo_ctrl #(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 15,
  parameter int SIZE       = 20000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_WIDTH-1:0] sample_in_i,
  input  logic                         sample_valid_i,
  input  logic        [ADDR_WIDTH-1:0] delay_i,
  input  logic        [7:0]            gain_i,
  output logic signed [DATA_WIDTH-1:0] sample_out_o,
  output logic                         out_valid_o,
  output logic                         busy_o,
  output logic                         overrun_o,
  output logic                         mem_we_o,
  output logic        [ADDR_WIDTH-1:0] mem_addr1_o,
  output logic        [ADDR_WIDTH-1:0] mem_addr2_o,
  output logic signed [DATA_WIDTH-1:0] mem_di_o,
  input  logic signed [DATA_WIDTH-1:0] mem_do2_i
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int PW = DW + 9;
  localparam int SW = DW + 2;
  localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);
  localparam logic [AW-1:0] DMAX = AW'(SIZE - 1);
  localparam logic signed [SW-1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {3'b111, {(DW-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, RD, W1, W2, MIX, WR} state_t;
  state_t state_q;
  logic signed [DW-1:0] in_q, echo_q, out_q, di_q, sat_d;
  logic [7:0] gain_q;
  logic [AW-1:0] dly_q, dly_d, raddr_d, wr_ptr_q, addr1_q, addr2_q;
  logic [AW:0] fill_q;
  logic valid_q, busy_q, overrun_q, we_q;
  logic signed [PW-1:0] prod_d;
  logic signed [SW-1:0] sum_d;
  always_comb begin
    dly_d   = (delay_i == '0) ? AW'(1) : ({1'b0, delay_i} >= SIZE_W) ? DMAX : delay_i;
    raddr_d = AW'({1'b0, wr_ptr_q} + ((wr_ptr_q >= dly_d) ? '0 : SIZE_W) - {1'b0, dly_d});
    prod_d  = {{9{echo_q[DW-1]}}, echo_q} * {{(PW-8){1'b0}}, gain_q};
    sum_d   = {{2{in_q[DW-1]}}, in_q} + SW'(prod_d >>> 8);
    sat_d   = (sum_d > SMAX) ? SMAX[DW-1:0] : (sum_d < SMIN) ? SMIN[DW-1:0] : sum_d[DW-1:0];
  end
  // Memory contents are undefined after reset, so slots older than the fill level read as silence
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      in_q      <= '0;
      echo_q    <= '0;
      out_q     <= '0;
      di_q      <= '0;
      gain_q    <= '0;
      dly_q     <= '0;
      wr_ptr_q  <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      fill_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      if (sample_valid_i && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (sample_valid_i) begin
          in_q    <= sample_in_i;
          gain_q  <= gain_i;
          dly_q   <= dly_d;
          addr2_q <= raddr_d;
          busy_q  <= 1'b1;
          state_q <= RD;
        end
        RD: state_q <= W1;
        W1: state_q <= W2;
        W2: begin
          echo_q  <= (fill_q < {1'b0, dly_q}) ? '0 : mem_do2_i;
          state_q <= MIX;
        end
        MIX: begin
          out_q   <= sat_d;
          di_q    <= sat_d;
          addr1_q <= wr_ptr_q;
          we_q    <= 1'b1;
          valid_q <= 1'b1;
          state_q <= WR;
        end
        WR: begin
          we_q     <= 1'b0;
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
          wr_ptr_q <= (wr_ptr_q == DMAX) ? '0 : wr_ptr_q + 1'b1;
          fill_q   <= (fill_q == SIZE_W) ? fill_q : fill_q + 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sample_out_o = out_q;
  assign out_valid_o  = valid_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;
  assign mem_we_o     = we_q;
  assign mem_addr1_o  = addr1_q;
  assign mem_addr2_o  = addr2_q;
  assign mem_di_o     = di_q;
endmodule

// File: tb/tb_echo_ctrl.sv
// tb_echo_ctrl: two echo_ctrl instances (deep and 8-deep buffer) on shared stimulus, each with a 2-cycle RAM,
// checked every cycle against a sample-history model plus hand-computed literals
module tb_echo_ctrl;
  localparam int DW = 31;
  localparam int AW = 15;
  localparam int SZ0 = 20000;
  localparam int SZ1 = 8;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));
  logic clk = 1'b0, rst = 1'b1, vld = 1'b0;
  logic signed [DW-1:0] sin = '0;
  logic [AW-1:0] dly = '0;
  logic [7:0] gn = '0;
  int errs = 0, nchk = 0;
  bit en = 1'b0;
  int got_out[2], got_ra[2], got_wa[2];
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int SZ = (g == 0) ? SZ0 : SZ1;
    logic signed [DW-1:0] so, di, r1, do2;
    logic ovld, busy, ovr, we;
    logic [AW-1:0] a1, a2;
    logic signed [DW-1:0] ram [2**AW];
    int phase = 0, n = 0, nxt = 0, cur_out = 0, cur_ra = 0, cur_wa = 0;
    bit m_ovr = 1'b0;
    int hist [64];
    echo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ)) u_dut (
      .clk_i(clk), .rst_i(rst), .sample_in_i(sin), .sample_valid_i(vld), .delay_i(dly), .gain_i(gn),
      .sample_out_o(so), .out_valid_o(ovld), .busy_o(busy), .overrun_o(ovr), .mem_we_o(we),
      .mem_addr1_o(a1), .mem_addr2_o(a2), .mem_di_o(di), .mem_do2_i(do2)
    );
    always @(posedge clk) begin
      if (we) ram[a1] <= di;
      r1  <= ram[a2];
      do2 <= r1;
    end
    function automatic int clampd();
      int x;
      x = int'(dly);
      return (x == 0) ? 1 : (x >= SZ) ? SZ - 1 : x;
    endfunction
    function automatic int rd_addr();
      int d;
      d = clampd();
      return ((n - d) % SZ + SZ) % SZ;
    endfunction
    // output = in + floor(echo*gain/256), saturated; echo = output d samples back, silence before that
    function automatic int mix();
      int d;
      longint e, p, f, s;
      d = clampd();
      e = 0;
      if (n >= d) e = longint'(hist[n - d]);
      p = e * longint'(gn);
      f = (p >= 0) ? p / 256 : -((-p + 255) / 256);
      s = longint'(sin) + f;
      if (s > longint'(MAXV)) s = longint'(MAXV);
      if (s < longint'(MINV)) s = longint'(MINV);
      return int'(s);
    endfunction
    always @(posedge clk) begin
      if (rst) begin
        phase <= 0; n <= 0; m_ovr <= 1'b0; cur_out <= 0; cur_ra <= 0; cur_wa <= 0;
      end else begin
        if (vld && phase != 0) m_ovr <= 1'b1;
        if (phase == 0 && vld) begin
          cur_ra <= rd_addr(); nxt <= mix(); phase <= 1;
        end else if (phase == 4) begin
          cur_out <= nxt; cur_wa <= n % SZ; phase <= 5;
        end else if (phase == 5) begin
          hist[n] <= cur_out; n <= n + 1; phase <= 0;
        end else if (phase != 0) phase <= phase + 1;
      end
    end
    always @(negedge clk) if (en) begin
      chk($sformatf("busy[%0d]", g), int'(busy), int'(phase != 0));
      chk($sformatf("out_valid[%0d]", g), int'(ovld), int'(phase == 5));
      chk($sformatf("mem_we[%0d]", g), int'(we), int'(phase == 5));
      chk($sformatf("overrun[%0d]", g), int'(ovr), int'(m_ovr));
      chk($sformatf("sample_out[%0d]", g), int'(so), cur_out);
      chk($sformatf("mem_di[%0d]", g), int'(di), cur_out);
      chk($sformatf("mem_addr1[%0d]", g), int'(a1), cur_wa);
      chk($sformatf("mem_addr2[%0d]", g), int'(a2), cur_ra);
    end
  end
  task automatic op(input int si, input int dl, input int gv, input bit poke);
    @(negedge clk); vld = 1'b1; sin = DW'(si); dly = AW'(dl); gn = 8'(gv);
    @(negedge clk); vld = 1'b0;
    got_ra[0] = int'(gi[0].a2); got_ra[1] = int'(gi[1].a2);
    @(negedge clk); vld = poke;
    @(negedge clk); vld = 1'b0;
    repeat (2) @(negedge clk);
    got_out[0] = int'(gi[0].so); got_out[1] = int'(gi[1].so);
    got_wa[0] = int'(gi[0].a1); got_wa[1] = int'(gi[1].a1);
    chk("strobe_at_5", int'(gi[0].ovld), 1);
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask
  initial begin
    int ins[5], exps[5];
    ins = '{1000, 0, 0, 0, 0};
    exps = '{1000, 0, 0, 0, 500};
    @(negedge clk); rst = 1'b0; en = 1'b1;
    chk("rst_out", int'(gi[0].so), 0);
    chk("rst_busy", int'(gi[0].busy), 0);
    chk("rst_we", int'(gi[1].we), 0);
    for (int i = 0; i < 10; i++) begin
      op(i * 1000 - 3000, 3, 100 + i * 13, 1'b0);
      chk("wrap_wa_small", got_wa[1], i % 8);
      chk("wrap_wa_big", got_wa[0], i);
    end
    chk("wrap_ra_small", got_ra[1], 6);
    op(123, 0, 50, 1'b0);
    chk("clamp0_small", got_ra[1], 1);
    chk("clamp0_big", got_ra[0], 9);
    op(-456, 9, 50, 1'b0);
    chk("clamp9_small", got_ra[1], 4);
    chk("noclamp9_big", got_ra[0], 2);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      op(ins[i], 4, 128, 1'b0);
      chk("echo_out_big", got_out[0], exps[i]);
      chk("echo_out_small", got_out[1], exps[i]);
    end
    chk("echo_ra4", got_ra[0], 0);
    chk("echo_wa4", got_wa[0], 4);
    do_reset();
    op(MAXV, 1, 0, 1'b0);
    op(MAXV, 1, 255, 1'b0);
    chk("sat_pos", got_out[0], 1073741823);
    do_reset();
    op(MINV, 1, 0, 1'b0);
    op(MINV, 1, 255, 1'b0);
    chk("sat_neg", got_out[1], -1073741824);
    do_reset();
    op(500, 2, 64, 1'b1);
    chk("ovr_out", got_out[0], 500);
    chk("ovr_set", int'(gi[0].ovr), 1);
    op(-300, 1, 64, 1'b0);
    chk("mix_neg", got_out[0], -175);
    op(0, 1, 3, 1'b0);
    chk("floor_neg", got_out[1], -3);
    chk("ovr_sticky", int'(gi[1].ovr), 1);
    do_reset();
    chk("ovr_clr", int'(gi[0].ovr), 0);
    @(negedge clk); vld = 1'b1; sin = DW'(777); dly = AW'(3); gn = 8'(200);
    @(negedge clk); vld = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_busy", int'(gi[0].busy), 0);
    chk("midrst_we", int'(gi[1].we), 0);
    op(42, 1, 255, 1'b0);
    chk("post_rst_out", got_out[1], 42);
    chk("post_rst_wa", got_wa[1], 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
